pipeline_ctrl: RTL and testbench

//  Central hazard/exception controller. Drives the stall vector and flush into every pipeline register (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipeline_ctrl_pkg.sv | 37 +++
 rtl/pipeline_ctrl_sat_counter.sv | 23 ++
 rtl/pipeline_ctrl.sv | 105 ++++++++++
 tb/tb_pipeline_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/exception controller:
// stall-bus layout, controller state codes and the default exception vector.
package pipeline_ctrl_pkg;

  localparam int unsigned STALL_BUS_WIDTH = 6;

  typedef logic [STALL_BUS_WIDTH-1:0] stall_bus_t;

  // Bit order is {wb, mem, ex, id, if, pc}.
  localparam stall_bus_t STALL_NONE   = 6'b000000;
  localparam stall_bus_t STALL_IF     = 6'b000011;
  localparam stall_bus_t STALL_ID     = 6'b000111;
  localparam stall_bus_t STALL_EX     = 6'b001111;
  localparam stall_bus_t STALL_MEM    = 6'b011111;
  localparam stall_bus_t STALL_FREEZE = 6'b111111;

  localparam logic [31:0] PCTRL_EXC_VECTOR = 32'hBFC00380;

  typedef enum logic [1:0] {
    PctrlRun   = 2'd0,
    PctrlPend  = 2'd1,
    PctrlFlush = 2'd2
  } pctrl_state_t;

  // The highest requesting stage wins; the stage below it receives the bubble.
  function automatic stall_bus_t encode_stall(input logic req_if, input logic req_id,
                                              input logic req_ex, input logic req_mem);
    stall_bus_t enc;
    if (req_mem)     enc = STALL_MEM;
    else if (req_ex) enc = STALL_EX;
    else if (req_id) enc = STALL_ID;
    else if (req_if) enc = STALL_IF;
    else             enc = STALL_NONE;
    return enc;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter used for performance statistics; sticks at all-ones.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central hazard/exception controller: encodes per-stage stall requests, freezes the
// pipeline on an exception/ERET from MEM, and issues a one-cycle flush with the PC redirect.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]  EXC_VECTOR = ADDR_WIDTH'(PCTRL_EXC_VECTOR),
  parameter int unsigned            CNT_WIDTH  = 32
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_stall_req_if,
  input  logic                       i_stall_req_id,
  input  logic                       i_stall_req_ex,
  input  logic                       i_stall_req_mem,
  input  logic                       i_exc_req,
  input  logic                       i_exc_is_eret,
  input  logic [ADDR_WIDTH-1:0]      i_epc_in,
  output logic [STALL_BUS_WIDTH-1:0] o_stall,
  output logic                       o_flush,
  output logic [ADDR_WIDTH-1:0]      o_redirect_pc,
  output logic                       o_busy_exc,
  output logic [CNT_WIDTH-1:0]       o_stall_cycles
);

  pctrl_state_t          r_state;
  logic                  r_flush;
  logic                  r_busy_exc;
  logic [ADDR_WIDTH-1:0] r_target;
  logic [ADDR_WIDTH-1:0] r_redirect_pc;
  logic [ADDR_WIDTH-1:0] w_exc_target;
  stall_bus_t            w_stall;

  assign w_exc_target = i_exc_is_eret ? i_epc_in : EXC_VECTOR;

  // Reset forces a quiet stall bus even while requests are still asserted.
  always_comb begin
    w_stall = STALL_NONE;
    if (!i_rst) begin
      case (r_state)
        PctrlRun: begin
          if (i_exc_req) begin
            w_stall = STALL_FREEZE;
          end else begin
            w_stall = encode_stall(i_stall_req_if, i_stall_req_id, i_stall_req_ex,
                                   i_stall_req_mem);
          end
        end
        PctrlPend: w_stall = STALL_FREEZE;
        default:   w_stall = STALL_NONE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= PctrlRun;
      r_flush       <= 1'b0;
      r_busy_exc    <= 1'b0;
      r_target      <= '0;
      r_redirect_pc <= '0;
    end else begin
      r_flush <= 1'b0;
      case (r_state)
        PctrlRun: begin
          if (i_exc_req) begin
            r_target <= w_exc_target;
            if (i_stall_req_mem) begin
              r_state    <= PctrlPend;
              r_busy_exc <= 1'b1;
            end else begin
              r_state       <= PctrlFlush;
              r_flush       <= 1'b1;
              r_redirect_pc <= w_exc_target;
            end
          end
        end
        PctrlPend: begin
          if (!i_stall_req_mem) begin
            r_state       <= PctrlFlush;
            r_flush       <= 1'b1;
            r_busy_exc    <= 1'b0;
            r_redirect_pc <= r_target;
          end
        end
        default: r_state <= PctrlRun;
      endcase
    end
  end

  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_stall_cnt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_inc   (w_stall[0]),
    .o_count (o_stall_cycles)
  );

  assign o_stall       = w_stall;
  assign o_flush       = r_flush;
  assign o_redirect_pc = r_redirect_pc;
  assign o_busy_exc    = r_busy_exc;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: stall-encoding table, directed exception
// sequences, reset-in-PEND, counter saturation and a randomized run against a reference model.
module tb_pipeline_ctrl;

  localparam logic [31:0] VEC = 32'hBFC00380;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_if = 0, req_id = 0, req_ex = 0, req_mem = 0;
  logic        exc = 0, eret = 0;
  logic [31:0] epc = '0;
  logic [5:0]  stall;
  logic        flush, busy;
  logic [31:0] redirect, cnt;

  logic        sat_req = 1'b0;
  logic [5:0]  sat_stall;
  logic        sat_flush, sat_busy;
  logic [31:0] sat_redirect;
  logic [3:0]  sat_cnt;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: what the controller has promised, in spec terms.
  bit          m_flush, m_waiting;
  logic [31:0] m_redirect, m_target, m_cnt;
  logic [5:0]  obs_stall;
  logic        obs_flush, obs_busy;
  logic [31:0] obs_redirect, obs_cnt;

  always #5 clk = ~clk;

  pipeline_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_stall_req_if(req_if), .i_stall_req_id(req_id),
    .i_stall_req_ex(req_ex), .i_stall_req_mem(req_mem), .i_exc_req(exc),
    .i_exc_is_eret(eret), .i_epc_in(epc), .o_stall(stall), .o_flush(flush),
    .o_redirect_pc(redirect), .o_busy_exc(busy), .o_stall_cycles(cnt)
  );

  pipeline_ctrl #(.CNT_WIDTH(4)) dut_sat (
    .i_clk(clk), .i_rst(rst), .i_stall_req_if(sat_req), .i_stall_req_id(1'b0),
    .i_stall_req_ex(1'b0), .i_stall_req_mem(1'b0), .i_exc_req(1'b0),
    .i_exc_is_eret(1'b0), .i_epc_in(32'h0), .o_stall(sat_stall), .o_flush(sat_flush),
    .o_redirect_pc(sat_redirect), .o_busy_exc(sat_busy), .o_stall_cycles(sat_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] ref_stall(input logic [3:0] req, input logic e);
    if (m_flush) return 6'd0;
    if (m_waiting || e) return 6'b111111;
    for (int s = 3; s >= 0; s--) if (req[s]) return 6'((1 << (s + 2)) - 1);
    return 6'd0;
  endfunction

  task automatic model_reset();
    m_flush = 0; m_waiting = 0; m_redirect = '0; m_target = '0; m_cnt = '0;
  endtask

  // One clock: drive at negedge, check just after, advance the model past posedge.
  task automatic cycle(input logic [3:0] req, input logic e, input logic er,
                       input logic [31:0] pc);
    logic [5:0] es;
    bit nf;
    @(negedge clk);
    {req_mem, req_ex, req_id, req_if} = req;
    exc = e; eret = er; epc = pc;
    #1;
    es = ref_stall(req, e);
    obs_stall = stall; obs_flush = flush; obs_busy = busy;
    obs_redirect = redirect; obs_cnt = cnt;
    chk("stall", 64'(stall), 64'(es));
    chk("flush", 64'(flush), 64'(m_flush));
    chk("busy_exc", 64'(busy), 64'(m_waiting));
    chk("redirect_pc", 64'(redirect), 64'(m_redirect));
    chk("stall_cycles", 64'(cnt), 64'(m_cnt));
    @(posedge clk);
    nf = 0;
    if (m_flush) begin
      nf = 0;
    end else if (m_waiting) begin
      if (!req[3]) begin nf = 1; m_redirect = m_target; m_waiting = 0; end
    end else if (e) begin
      m_target = er ? pc : VEC;
      if (req[3]) m_waiting = 1;
      else begin nf = 1; m_redirect = m_target; end
    end
    m_flush = nf;
    if (es[0] && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
  endtask

  task automatic idle();
    cycle(4'b0000, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    {req_mem, req_ex, req_id, req_if} = 4'b0;
    exc = 0; eret = 0; rst = 1;
    #1;
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_flush", 64'(flush), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_redirect", 64'(redirect), 64'd0);
    chk("rst_cnt", 64'(cnt), 64'd0);
    @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  typedef struct {
    logic [3:0] req;  // {mem, ex, id, if}
    logic [5:0] exp;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{4'b0000, 6'b000000};
    tbl[1] = '{4'b0001, 6'b000011};
    tbl[2] = '{4'b0010, 6'b000111};
    tbl[3] = '{4'b0100, 6'b001111};
    tbl[4] = '{4'b1000, 6'b011111};
    tbl[5] = '{4'b1010, 6'b011111};
    tbl[6] = '{4'b0011, 6'b000111};
    tbl[7] = '{4'b0111, 6'b001111};
    tbl[8] = '{4'b1111, 6'b011111};
    tbl[9] = '{4'b0101, 6'b001111};

    model_reset();
    do_reset();

    // Stall encoding table
    foreach (tbl[i]) begin
      cycle(tbl[i].req, 1'b0, 1'b0, 32'h0);
      chk($sformatf("tbl%0d_stall", i), 64'(obs_stall), 64'(tbl[i].exp));
    end

    // EX busy for three cycles, counter from reset
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(4'b0100, 1'b0, 1'b0, 32'h0);
      chk("ex_stall", 64'(obs_stall), 64'(6'b001111));
    end
    idle();
    chk("ex_release", 64'(obs_stall), 64'd0);
    chk("ex_count", 64'(obs_cnt), 64'd3);

    // Exception without bus wait; requests during FLUSH are ignored
    cycle(4'b0010, 1'b1, 1'b0, 32'h1111_0000);
    chk("exc_freeze", 64'(obs_stall), 64'(6'b111111));
    chk("exc_no_flush_yet", 64'(obs_flush), 64'd0);
    cycle(4'b1100, 1'b1, 1'b1, 32'h2222_0000);
    chk("exc_flush", 64'(obs_flush), 64'd1);
    chk("exc_redirect", 64'(obs_redirect), 64'(VEC));
    chk("flush_stall_zero", 64'(obs_stall), 64'd0);
    idle();
    chk("exc_flush_drop", 64'(obs_flush), 64'd0);
    chk("exc_redirect_hold", 64'(obs_redirect), 64'(VEC));

    // Exception waiting on the data bus
    cycle(4'b1000, 1'b1, 1'b0, 32'h0);
    chk("pend_accept_freeze", 64'(obs_stall), 64'(6'b111111));
    for (int i = 0; i < 4; i++) begin
      cycle(4'b1000, 1'b0, 1'b0, 32'h0);
      chk("pend_busy", 64'(obs_busy), 64'd1);
      chk("pend_freeze", 64'(obs_stall), 64'(6'b111111));
      chk("pend_no_flush", 64'(obs_flush), 64'd0);
    end
    idle();
    chk("pend_fall_freeze", 64'(obs_stall), 64'(6'b111111));
    idle();
    chk("pend_flush", 64'(obs_flush), 64'd1);
    chk("pend_busy_clear", 64'(obs_busy), 64'd0);
    idle();
    chk("pend_flush_once", 64'(obs_flush), 64'd0);

    // ERET with EPC changing during PEND
    cycle(4'b1000, 1'b1, 1'b1, 32'h8000_1234);
    cycle(4'b1000, 1'b1, 1'b0, 32'hDEAD_BEEF);
    cycle(4'b0000, 1'b1, 1'b1, 32'h5555_AAAA);
    idle();
    chk("eret_flush", 64'(obs_flush), 64'd1);
    chk("eret_redirect", 64'(obs_redirect), 64'(32'h8000_1234));

    // Reset while PEND discards the pending exception
    cycle(4'b1000, 1'b1, 1'b0, 32'h0);
    cycle(4'b1000, 1'b0, 1'b0, 32'h0);
    chk("pre_rst_busy", 64'(obs_busy), 64'd1);
    @(negedge clk);
    #2;
    rst = 1;
    #1;
    chk("rst_pend_stall", 64'(stall), 64'd0);
    chk("rst_pend_busy", 64'(busy), 64'd0);
    chk("rst_pend_flush", 64'(flush), 64'd0);
    chk("rst_pend_redirect", 64'(redirect), 64'd0);
    chk("rst_pend_cnt", 64'(cnt), 64'd0);
    @(negedge clk);
    {req_mem, req_ex, req_id, req_if} = 4'b0;
    exc = 0;
    rst = 0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("post_rst_no_flush", 64'(obs_flush), 64'd0);
    end

    // Saturation on the narrow-counter instance
    @(negedge clk);
    sat_req = 1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 14) chk("sat_count14", 64'(sat_cnt), 64'hE);
      if (i == 15) chk("sat_count15", 64'(sat_cnt), 64'hF);
      if (i == 20) chk("sat_hold", 64'(sat_cnt), 64'hF);
    end
    sat_req = 0;

    // Randomized run against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [3:0]  r;
      logic        e, er;
      logic [31:0] p;
      r  = 4'($urandom_range(0, 15));
      e  = ($urandom_range(0, 7) == 0);
      er = 1'($urandom);
      p  = $urandom;
      cycle(r, e, er, p);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
